// File: rtl/turtle_pkg.sv
// Shared types for the Turtle CPU run controller: run states and halt causes.
package turtle_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        RUN     = 3'd1,
        MANUAL  = 3'd2,
        BP_HALT = 3'd3,
        STEP    = 3'd4,
        HALTED  = 3'd5
    } run_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        BREAKPOINT = 2'd1,
        HALT_INSTR = 2'd2
    } halt_cause_t;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes one raw asynchronous input and debounces it into a stable level.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       stable_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // stable_cnt counts consecutive synced samples that disagree with level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(raw);
            if (synced == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= synced;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/turtle_run_controller.sv
// Generates the Turtle core clock enable: free-run, manual stepping,
// breakpoint/HALT stopping and an executed-cycle counter.
module turtle_run_controller
    import turtle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int PC_WIDTH        = 10,
    parameter int CYCLE_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       manual_clk_sw,
    input  logic                       pulse_clk_btn,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic                       halt_instr,
    input  logic                       bp_enable,
    input  logic [PC_WIDTH-1:0]        bp_addr,
    output logic                       cpu_clk_en,
    output logic [2:0]                 run_state,
    output logic [1:0]                 halt_cause,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);

    localparam int INIT_CYCLES = DEBOUNCE_CYCLES + SYNC_STAGES + 1;
    localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

    run_state_t        state_q, state_d;
    halt_cause_t       cause_q, cause_d;
    logic [INIT_W-1:0] init_cnt;
    logic              sw_level, btn_level, btn_level_q;
    logic              press, bp_hit, init_done;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_sw_db (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (manual_clk_sw),
        .level  (sw_level)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_btn_db (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (pulse_clk_btn),
        .level  (btn_level)
    );

    assign press     = btn_level & ~btn_level_q;
    assign bp_hit    = bp_enable && (pc == bp_addr);
    assign init_done = (init_cnt == INIT_W'(INIT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cause_q     <= NONE;
            init_cnt    <= '0;
            btn_level_q <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            btn_level_q <= btn_level;
            if (state_q == INIT && !init_done) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end
            if (cpu_clk_en && !(&cycle_count)) begin
                cycle_count <= cycle_count + CYCLE_CNT_WIDTH'(1);
            end
        end
    end

    // Enable is Mealy so a HALT or breakpoint suppresses the very cycle it appears in.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cpu_clk_en = 1'b0;
        case (state_q)
            INIT: begin
                if (init_done) state_d = sw_level ? MANUAL : RUN;
            end
            RUN: begin
                cpu_clk_en = !(halt_instr || bp_hit);
                if (halt_instr) begin
                    state_d = HALTED;
                    cause_d = HALT_INSTR;
                end else if (bp_hit) begin
                    state_d = BP_HALT;
                    cause_d = BREAKPOINT;
                end else if (sw_level) begin
                    state_d = MANUAL;
                end
            end
            MANUAL: begin
                cpu_clk_en = press && sw_level && !halt_instr;
                if (halt_instr) begin
                    state_d = HALTED;
                    cause_d = HALT_INSTR;
                end else if (!sw_level) begin
                    state_d = RUN;
                end
            end
            BP_HALT: begin
                if (press) begin
                    state_d = STEP;
                    cause_d = NONE;
                end
            end
            STEP: begin
                cpu_clk_en = !halt_instr;
                if (halt_instr) begin
                    state_d = HALTED;
                    cause_d = HALT_INSTR;
                end else begin
                    state_d = sw_level ? MANUAL : RUN;
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = INIT;
                cause_d = NONE;
            end
        endcase
    end

    assign run_state  = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_turtle_run_controller.sv
// Self-checking bench for turtle_run_controller: directed table, hand-written
// corner sequences and randomized stimulus against a queue-based model.
module tb_turtle_run_controller;
    import turtle_pkg::*;

    localparam int DB       = 4;
    localparam int SS       = 2;
    localparam int PW       = 10;
    localparam int CW       = 32;
    localparam int CW_S     = 4;
    localparam int INIT_LEN = DB + SS + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          manual_clk_sw = 1'b0;
    logic          pulse_clk_btn = 1'b0;
    logic          halt_instr = 1'b0;
    logic          bp_enable = 1'b0;
    logic [PW-1:0] pc = '0;
    logic [PW-1:0] bp_addr = '0;

    logic            cpu_clk_en, cpu_clk_en_s;
    logic [2:0]      run_state, run_state_s;
    logic [1:0]      halt_cause, halt_cause_s;
    logic [CW-1:0]   cycle_count;
    logic [CW_S-1:0] cycle_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    turtle_run_controller #(
        .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS), .PC_WIDTH(PW), .CYCLE_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .manual_clk_sw(manual_clk_sw),
        .pulse_clk_btn(pulse_clk_btn), .pc(pc), .halt_instr(halt_instr),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .cpu_clk_en(cpu_clk_en),
        .run_state(run_state), .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    // Narrow counter instance sharing the same stimulus, to exercise saturation.
    turtle_run_controller #(
        .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS), .PC_WIDTH(PW), .CYCLE_CNT_WIDTH(CW_S)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .manual_clk_sw(manual_clk_sw),
        .pulse_clk_btn(pulse_clk_btn), .pc(pc), .halt_instr(halt_instr),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .cpu_clk_en(cpu_clk_en_s),
        .run_state(run_state_s), .halt_cause(halt_cause_s), .cycle_count(cycle_count_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    run_state_t  m_state;
    halt_cause_t m_cause;
    int          m_init_age;
    longint      m_enables;
    bit          m_sw, m_btn, m_btn_prev;
    bit          sw_hist[$];
    bit          btn_hist[$];

    function automatic longint cap(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // hist holds raw samples per edge; the oldest DB entries are the synced
    // samples the debouncer judges at this edge.
    function automatic bit debounced(input bit hist[$], input bit lvl);
        for (int i = 0; i < DB; i++) if (hist[i] == lvl) return lvl;
        return !lvl;
    endfunction

    function automatic bit model_en(input bit hi, input bit bp, input bit press);
        case (m_state)
            RUN:     return !(hi || bp);
            MANUAL:  return press && m_sw && !hi;
            STEP:    return !hi;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = INIT; m_cause = NONE; m_init_age = 0; m_enables = 0;
        m_sw = 0; m_btn = 0; m_btn_prev = 0;
        sw_hist.delete(); btn_hist.delete();
        for (int i = 0; i < SS + DB - 1; i++) begin
            sw_hist.push_back(1'b0);
            btn_hist.push_back(1'b0);
        end
    endtask

    task automatic model_edge(input bit sw_raw, input bit btn_raw, input bit hi, input bit bp);
        bit press = m_btn && !m_btn_prev;
        if (model_en(hi, bp, press)) m_enables++;
        case (m_state)
            INIT: begin
                m_init_age++;
                if (m_init_age == INIT_LEN) m_state = m_sw ? MANUAL : RUN;
            end
            RUN: begin
                if (hi) begin m_state = HALTED; m_cause = HALT_INSTR; end
                else if (bp) begin m_state = BP_HALT; m_cause = BREAKPOINT; end
                else if (m_sw) m_state = MANUAL;
            end
            MANUAL: begin
                if (hi) begin m_state = HALTED; m_cause = HALT_INSTR; end
                else if (!m_sw) m_state = RUN;
            end
            BP_HALT: if (press) begin m_state = STEP; m_cause = NONE; end
            STEP: begin
                if (hi) begin m_state = HALTED; m_cause = HALT_INSTR; end
                else m_state = m_sw ? MANUAL : RUN;
            end
            default: ;
        endcase
        m_btn_prev = m_btn;
        sw_hist.push_back(sw_raw);
        btn_hist.push_back(btn_raw);
        while (sw_hist.size() > SS + DB) void'(sw_hist.pop_front());
        while (btn_hist.size() > SS + DB) void'(btn_hist.pop_front());
        m_sw  = debounced(sw_hist, m_sw);
        m_btn = debounced(btn_hist, m_btn);
    endtask

    // ---------------- driver tasks (entered/left #1 after posedge) ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_en", 64'(cpu_clk_en), 64'(0));
        check("rst_state", 64'(run_state), 64'(INIT));
        check("rst_cause", 64'(halt_cause), 64'(NONE));
        check("rst_cnt", 64'(cycle_count), 64'(0));
        check("rst_cnt_sat", 64'(cycle_count_s), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic rand_cycle();
        bit press, bp, en;
        if ($urandom_range(0, 59) == 0) manual_clk_sw = ~manual_clk_sw;
        if ($urandom_range(0, 5) == 0) pulse_clk_btn = ~pulse_clk_btn;
        halt_instr = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 19) == 0) bp_enable = ~bp_enable;
        pc = PW'($urandom_range(0, 7));
        @(negedge clk);
        press = m_btn && !m_btn_prev;
        bp    = bp_enable && (pc == bp_addr);
        en    = model_en(halt_instr, bp, press);
        check("rnd_en", 64'(cpu_clk_en), 64'(en));
        check("rnd_state", 64'(run_state), 64'(m_state));
        check("rnd_cause", 64'(halt_cause), 64'(m_cause));
        check("rnd_cnt", 64'(cycle_count), 64'(cap(m_enables, CW)));
        check("rnd_cnt_sat", 64'(cycle_count_s), 64'(cap(m_enables, CW_S)));
        model_edge(manual_clk_sw, pulse_clk_btn, halt_instr, bp);
        @(posedge clk);
        #1;
    endtask

    // Drives btn for n cycles in MANUAL, returns number of enable pulses seen.
    task automatic manual_btn(input bit b, input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            pulse_clk_btn = b;
            @(negedge clk);
            if (cpu_clk_en) pulses++;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          n;
        bit          sw;
        bit          btn;
        bit          hi;
        bit          bpe;
        logic [9:0]  pc;
        run_state_t  st;
        bit          en;
        halt_cause_t cause;
        int          cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int pulses, bad, seen_run, found;
        bit pat[18];

        tbl = '{
            '{7,  0, 0, 0, 1, 10'h010, INIT,    1'b0, NONE,       0},
            '{2,  0, 0, 0, 1, 10'h011, RUN,     1'b1, NONE,       -1},
            '{1,  0, 0, 0, 1, 10'h012, RUN,     1'b0, NONE,       2},
            '{3,  0, 0, 0, 1, 10'h012, BP_HALT, 1'b0, BREAKPOINT, 2},
            '{6,  0, 1, 0, 1, 10'h012, BP_HALT, 1'b0, BREAKPOINT, 2},
            '{1,  0, 1, 0, 1, 10'h012, BP_HALT, 1'b0, BREAKPOINT, 2},
            '{1,  0, 1, 0, 1, 10'h012, STEP,    1'b1, NONE,       2},
            '{17, 0, 1, 0, 1, 10'h013, RUN,     1'b1, NONE,       -1},
            '{1,  0, 1, 1, 1, 10'h012, RUN,     1'b0, NONE,       20},
            '{3,  0, 0, 0, 1, 10'h012, HALTED,  1'b0, HALT_INSTR, 20},
            '{8,  1, 1, 0, 1, 10'h000, HALTED,  1'b0, HALT_INSTR, 20},
            '{8,  0, 0, 0, 0, 10'h000, HALTED,  1'b0, HALT_INSTR, 20},
            '{8,  1, 1, 0, 0, 10'h012, HALTED,  1'b0, HALT_INSTR, 20}
        };

        @(posedge clk);
        #1;
        manual_clk_sw = 0; pulse_clk_btn = 0; bp_enable = 1; bp_addr = 10'h012; pc = 10'h010;
        do_reset();
        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                manual_clk_sw = tbl[r].sw;
                pulse_clk_btn = tbl[r].btn;
                halt_instr    = tbl[r].hi;
                bp_enable     = tbl[r].bpe;
                pc            = tbl[r].pc;
                @(negedge clk);
                check($sformatf("tbl[%0d].en", r), 64'(cpu_clk_en), 64'(tbl[r].en));
                check($sformatf("tbl[%0d].state", r), 64'(run_state), 64'(tbl[r].st));
                check($sformatf("tbl[%0d].cause", r), 64'(halt_cause), 64'(tbl[r].cause));
                if (tbl[r].cnt >= 0) begin
                    check($sformatf("tbl[%0d].cnt", r), 64'(cycle_count), 64'(tbl[r].cnt));
                    check($sformatf("tbl[%0d].cnt_sat", r), 64'(cycle_count_s),
                          64'((tbl[r].cnt > 15) ? 15 : tbl[r].cnt));
                end
                @(posedge clk);
                #1;
            end
        end

        // Manual stepping with a bouncing button; breakpoint armed on the PC.
        halt_instr = 0; bp_enable = 1; bp_addr = 10'h020; pc = 10'h020;
        manual_clk_sw = 1; pulse_clk_btn = 0;
        do_reset();
        for (int i = 0; i < INIT_LEN; i++) begin
            @(negedge clk);
            check("man_init_state", 64'(run_state), 64'(INIT));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("man_enter_manual", 64'(run_state), 64'(MANUAL));
        @(posedge clk);
        #1;
        pat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            manual_btn(pat[i], 1, pulses);
            bad += pulses;
        end
        check("man_bounce_pulses", 64'(bad), 64'(1));
        manual_btn(1'b0, 10, pulses);
        check("man_release_pulses", 64'(pulses), 64'(0));
        manual_btn(1'b1, 10, pulses);
        check("man_second_pulses", 64'(pulses), 64'(1));
        check("man_cnt", 64'(cycle_count), 64'(2));
        check("man_state_hold", 64'(run_state), 64'(MANUAL));

        // Switch falls on the same edge the press is recognised: no step.
        manual_btn(1'b0, 8, pulses);
        pulse_clk_btn = 1; manual_clk_sw = 0;
        bad = 0; seen_run = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (run_state == MANUAL && cpu_clk_en) bad++;
            if (run_state == RUN) seen_run = 1;
            @(posedge clk);
            #1;
        end
        check("drop_vs_press_steps", 64'(bad), 64'(0));
        check("drop_reached_run", 64'(seen_run), 64'(1));
        check("drop_bp_halt", 64'(run_state), 64'(BP_HALT));

        // Reset asserted in the middle of a STEP cycle.
        pulse_clk_btn = 0;
        repeat (8) @(posedge clk);
        #1;
        pulse_clk_btn = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (run_state == STEP) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("step_reached", 64'(found), 64'(1));
        check("step_en", 64'(cpu_clk_en), 64'(1));
        #1;
        reset_n = 0;
        #1;
        check("midstep_en", 64'(cpu_clk_en), 64'(0));
        check("midstep_state", 64'(run_state), 64'(INIT));
        check("midstep_cause", 64'(halt_cause), 64'(NONE));
        check("midstep_cnt", 64'(cycle_count), 64'(0));
        @(posedge clk);
        #1;

        // Randomized episodes against the model.
        for (int ep = 0; ep < 40; ep++) begin
            manual_clk_sw = 1'($urandom_range(0, 1));
            pulse_clk_btn = 0;
            halt_instr    = 0;
            bp_enable     = 1'($urandom_range(0, 1));
            bp_addr       = PW'($urandom_range(0, 7));
            pc            = '0;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 499) == 0) do_reset();
                rand_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turtle_run_controller.md
Name: turtle_run_controller

Overview:
- Sequences the Turtle CPU core by generating the single clock enable that gates every architectural state update (PC, register file, data memory, status).
- Free-run mode: enables every cycle.
- Manual mode (manual_clk_sw): one enable pulse per debounced press of pulse_clk_btn.
- Halts on a PC breakpoint or on the decoder's halt indication; counts executed cycles for the debug display.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable samples required before a debounced input changes level.
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input.
- PC_WIDTH, 10: width of pc and bp_addr.
- CYCLE_CNT_WIDTH, 32: width of cycle_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- manual_clk_sw  in  1  raw switch; 1 = manual stepping
- pulse_clk_btn  in  1  raw button; a press requests one step
- pc  in  PC_WIDTH  current program counter
- halt_instr  in  1  decoder: current instruction is HALT
- bp_enable  in  1  breakpoint armed
- bp_addr  in  PC_WIDTH  breakpoint address
- cpu_clk_en  out  1  core clock enable
- run_state  out  3  current state (run_state_t encoding)
- halt_cause  out  2  halt_cause_t: NONE, BREAKPOINT, HALT_INSTR
- cycle_count  out  CYCLE_CNT_WIDTH  count of cycles with cpu_clk_en=1

Behaviour:
- Reset:
  - Asynchronous, active-low. Clock is clk; reset is reset_n.
  - While reset_n=0: state INIT, cpu_clk_en=0, halt_cause=NONE, cycle_count=0, all synchronizer/debounce state 0.
- Input conditioning:
  - Both raw inputs: SYNC_STAGES-flop synchronizer, then debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synced samples that differ from the current level.
  - press = one-cycle pulse on the debounced button's 0->1 edge. Release is ignored.
- Breakpoint condition: bp_hit = bp_enable && (pc == bp_addr).
- cpu_clk_en is combinational from state and current-cycle conditions (Mealy). A halting instruction is therefore never executed.
- INIT:
  - cpu_clk_en=0. Held for exactly DEBOUNCE_CYCLES+SYNC_STAGES+1 cycles after reset release.
  - Then go to MANUAL if debounced switch=1, else RUN. Presses during INIT are discarded.
- RUN:
  - cpu_clk_en = !(halt_instr || bp_hit).
  - halt_instr -> HALTED, halt_cause=HALT_INSTR.
  - Else bp_hit -> BP_HALT, halt_cause=BREAKPOINT.
  - Else debounced switch=1 -> MANUAL.
  - Priority: halt_instr > bp_hit > switch.
- MANUAL:
  - cpu_clk_en = press && !halt_instr. Breakpoints are ignored, so stepping always moves past a breakpoint.
  - halt_instr -> HALTED.
  - Debounced switch=0 -> RUN. If the switch drops on the same cycle as press, the switch wins and no step is issued.
- BP_HALT:
  - cpu_clk_en=0.
  - press -> STEP: exactly one enable cycle with no breakpoint check, stepping off bp_addr.
  - From STEP, next state is MANUAL if switch=1, else RUN. halt_cause returns to NONE on leaving BP_HALT.
  - halt_instr during STEP blocks the enable and goes to HALTED.
- HALTED:
  - cpu_clk_en=0. Sticky; exit only via reset_n.
- cycle_count: increments by 1 on every clk edge where cpu_clk_en=1; saturates at all-ones with no wrap.
- Reset mid-operation: immediate return to INIT. Any in-progress step is lost.

Decomposition:
- turtle_pkg holds:
  - run_state_t: INIT, RUN, MANUAL, BP_HALT, STEP, HALTED.
  - halt_cause_t: NONE, BREAKPOINT, HALT_INSTR.
- Sub-module input_debouncer (synchronizer + stable counter + level register), parameterized by DEBOUNCE_CYCLES and SYNC_STAGES, instantiated twice. Press-edge detection lives in the top level.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset with switch=0, pc incrementing -> INIT held 7 cycles with cpu_clk_en=0, then RUN with cpu_clk_en=1 every cycle; after 20 enabled cycles cycle_count=20.
- bp_enable=1, bp_addr=0x012, pc reaches 0x012 -> cpu_clk_en=0 that same cycle, run_state=BP_HALT, halt_cause=BREAKPOINT. One clean press -> exactly one enable cycle, then back in RUN with halt_cause=NONE.
- Switch=1 held, button bounces 1-0-1-0 at 2-cycle intervals then holds 1 for 10 cycles -> exactly one cpu_clk_en pulse; release and a second clean press -> exactly one more pulse.
- halt_instr=1 in RUN with bp_hit also true -> HALTED with halt_cause=HALT_INSTR. Further presses and switch toggles give no enables; only reset_n exits.
- cycle_count preset path with CYCLE_CNT_WIDTH=4, 20 enabled cycles -> cycle_count saturates at 0xF.
- Assert reset_n=0 mid-STEP -> cpu_clk_en drops asynchronously, cycle_count=0, run_state=INIT.
